// File: rtl/cpu_result_checker.sv
// End-of-program checker for the single-cycle MIPS CPU: detects a halted PC or a
// cycle timeout, then compares up to NCHK observed register values against expectations.
module cpu_result_checker #(
   parameter int WIDTH         = 32,
   parameter int NCHK          = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT       = 1000,
   parameter int CNTW          = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WIDTH-1:0]       pc,
   input  logic [NCHK*WIDTH-1:0]  chk_val,
   input  logic [NCHK*WIDTH-1:0]  chk_exp,
   input  logic [NCHK-1:0]        chk_en,
   output logic                   busy,
   output logic                   done,
   output logic                   passed,
   output logic                   timed_out,
   output logic [NCHK-1:0]        fail_mask,
   output logic [CNTW-1:0]        cycle_count
);

   localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam int IW = (NCHK > 1) ? $clog2(NCHK) : 1;

   localparam logic [SW-1:0]   STABLE_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [IW-1:0]   IDX_LAST    = IW'(NCHK - 1);
   localparam logic [CNTW-1:0] TMO         = CNTW'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  prev_pc_q;
   logic [SW-1:0]     stable_q;
   logic [IW-1:0]     idx_q;
   logic [CNTW-1:0]   cnt_next;
   logic              pc_same;
   logic              halt;
   logic              hit_timeout;
   logic              chan_bad;

   assign pc_same     = (pc == prev_pc_q);
   assign halt        = pc_same && (stable_q == STABLE_LAST);
   assign cnt_next    = (cycle_count < TMO) ? cycle_count + 1'b1 : cycle_count;
   assign hit_timeout = (cnt_next == TMO);
   // Channel values are sampled live, so the CPU must stay halted through CHECK.
   assign chan_bad    = chk_en[idx_q] &&
                        (chk_val[idx_q*WIDTH +: WIDTH] != chk_exp[idx_q*WIDTH +: WIDTH]);

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_RUN;
         S_RUN:          if (halt || hit_timeout) state_d = S_CHECK;
         S_CHECK:        if (idx_q == IDX_LAST) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         prev_pc_q   <= '0;
         stable_q    <= '0;
         idx_q       <= '0;
         cycle_count <= '0;
         fail_mask   <= '0;
         timed_out   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  prev_pc_q   <= pc;
                  stable_q    <= '0;
                  idx_q       <= '0;
                  cycle_count <= '0;
                  fail_mask   <= '0;
                  timed_out   <= 1'b0;
               end
            end
            S_RUN: begin
               cycle_count <= cnt_next;
               prev_pc_q   <= pc;
               stable_q    <= (pc_same && !halt) ? stable_q + 1'b1 : '0;
               // A halt on the timeout cycle takes priority and is not a timeout.
               if (!halt && hit_timeout) timed_out <= 1'b1;
            end
            S_CHECK: begin
               if (chan_bad) fail_mask[idx_q] <= 1'b1;
               idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state_q == S_RUN) || (state_q == S_CHECK);
   assign done   = (state_q == S_DONE);
   assign passed = done && (fail_mask == '0) && !timed_out;

endmodule
